dffx_load_sched: RTL

//  Round-robin scheduler sharing one W-bit X-aware capture register (DFFx array) between N requesters.
//  Per grant: drive data + valid into the register for one cycle, then wait until its metastability (M)
//  and transition (T) flags stay clean for SETTLE_CYC consecutive cycles; return captured Q with ack.

---
 rtl/dffx_load_sched_pkg.sv | 24 ++
 rtl/dffx_load_sched_if.sv | 34 +++
 rtl/dffx_load_sched_rr_arbiter.sv | 40 ++++
 rtl/dffx_load_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dffx_load_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dffx_sched_pkg
// Brief    : Shared types and helpers for the DFFx load scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dffx_sched_pkg;

    // Scheduler sequence: pick requester, load register, wait for clean flags,
    // report completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Width able to hold every count value from 0 up to and including max_wait.
    function automatic int cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffx_load_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dffx_load_sched_if
// Brief    : Requester bus plus capture-register side-band of the scheduler.
//            master = requesters / capture register, slave = scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface dffx_load_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   ack;
    logic           err;
    logic [W-1:0]   rdata;
    logic           busy;
    logic [W-1:0]   cap_d;
    logic           cap_v;
    logic [W-1:0]   cap_q;
    logic           cap_m;
    logic           cap_t;

    modport master (
        output req, data, cap_q, cap_m, cap_t,
        input  ack, err, rdata, busy, cap_d, cap_v
    );

    modport slave (
        input  req, data, cap_q, cap_m, cap_t,
        output ack, err, rdata, busy, cap_d, cap_v
    );
endinterface
`default_nettype wire

// File: rtl/dffx_load_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first asserted request found
//            searching from i_ptr upwards, wrapping N-1 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_ptr,
    output logic      [N-1:0]  o_grant,
    output logic      [IW-1:0] o_grant_idx,
    output logic               o_any
);

    // Scan priority from lowest to highest so the entry closest to i_ptr is written last and wins.
    always_comb begin
        int j;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        j           = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_req[j]) begin
                o_any       = 1'b1;
                o_grant_idx = IW'(j);
            end
        end
        o_grant[o_grant_idx] = o_any;
    end

endmodule
`default_nettype wire

// File: rtl/dffx_load_sched.sv
`default_nettype none
// ============================================================================
// Module   : dffx_load_sched
// Brief    : Round-robin scheduler time-sharing one X-aware capture register
//            among N requesters. Each grant loads the register for one cycle,
//            waits for SETTLE_CYC consecutive clean M/T cycles (or MAX_WAIT
//            timeout) and returns the captured value with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module dffx_load_sched
    import dffx_sched_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_WAIT   = 16
) (
    input  wire logic         CK,
    input  wire logic         RS,
    dffx_load_sched_if.slave  bus
);

    localparam int c_IW = $clog2(N);
    localparam int c_CW = cnt_w(MAX_WAIT);

    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE_CYC);
    localparam logic [c_CW-1:0] c_MAXW   = c_CW'(MAX_WAIT);
    localparam logic [c_CW-1:0] c_CNT1   = c_CW'(1);
    localparam logic [c_IW-1:0] c_LAST   = c_IW'(N - 1);
    localparam logic [c_IW-1:0] c_IDX1   = c_IW'(1);

    state_e          state_q, state_d;
    logic [c_IW-1:0] ptr_q, ptr_d;
    logic [c_IW-1:0] grant_q, grant_d;
    logic [N-1:0]    grant_oh_q, grant_oh_d;
    logic [c_CW-1:0] clean_cnt_q, clean_cnt_d;
    logic [c_CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [W-1:0]    rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [N-1:0]    w_arb_oh;
    logic [c_IW-1:0] w_arb_idx;
    logic            w_arb_any;
    logic [N-1:0]    w_ack;
    logic            w_cap_v;
    logic [W-1:0]    w_cap_d;

    rr_arbiter #(
        .N  (N),
        .IW (c_IW)
    ) u_arb (
        .i_req       (bus.req),
        .i_ptr       (ptr_q),
        .o_grant     (w_arb_oh),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    // State, pointer, counters and result registers.
    always_ff @(posedge CK) begin
        if (RS) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            clean_cnt_q <= '0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_oh_q  <= grant_oh_d;
            clean_cnt_q <= clean_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic and the capture-register / ack drive for the current state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        clean_cnt_d = clean_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        w_ack       = '0;
        w_cap_v     = 1'b0;
        w_cap_d     = '0;

        case (state_q)
            IDLE: begin
                if (w_arb_any) begin
                    grant_d    = w_arb_idx;
                    grant_oh_d = w_arb_oh;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // Data is committed here; later req/data changes cannot affect the result.
                w_cap_v     = 1'b1;
                w_cap_d     = bus.data[int'(grant_q) * W +: W];
                clean_cnt_d = '0;
                wait_cnt_d  = '0;
                state_d     = SETTLE;
            end
            SETTLE: begin
                wait_cnt_d  = wait_cnt_q + c_CNT1;
                clean_cnt_d = (bus.cap_m | bus.cap_t) ? '0 : clean_cnt_q + c_CNT1;
                // Success is tested first so it wins when both limits land together.
                if (clean_cnt_d == c_SETTLE) begin
                    rdata_d = bus.cap_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wait_cnt_d == c_MAXW) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                w_ack   = grant_oh_q;
                ptr_d   = (grant_q == c_LAST) ? '0 : grant_q + c_IDX1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack   = w_ack;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.cap_v = w_cap_v;
    assign bus.cap_d = w_cap_d;

endmodule
`default_nettype wire
